// File: rtl/stack_bus_upstream_arbiter.sv
// stack_bus_upstream_arbiter: N-to-1 upstream stack-bus concentrator with per-source FIFOs and packet-granular round-robin
module stack_bus_upstream_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int SRC_ID_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset_poweron,
    input  logic [NUM_SRC-1:0]        src__arb__valid,
    input  logic [2*NUM_SRC-1:0]      src__arb__cntl,
    input  logic [NUM_SRC*DATA_W-1:0] src__arb__data,
    output logic [NUM_SRC-1:0]        arb__src__ready,
    input  logic [NUM_SRC-1:0]        cfg__arb__src_enable,
    output logic                      arb__dst__valid,
    output logic [1:0]                arb__dst__cntl,
    output logic [DATA_W-1:0]         arb__dst__data,
    output logic [SRC_ID_W-1:0]       arb__dst__src_id,
    input  logic                      dst__arb__ready,
    output logic                      arb__sys__busy,
    output logic                      arb__sys__proto_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = DATA_W + 2;

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state, state_nxt;
    logic [SRC_ID_W-1:0] rr, rr_nxt, grant, grant_nxt, win, idx;
    logic                found, drop;
    logic [NUM_SRC-1:0]  empty, pop, cand;
    logic [WW-1:0]       head [NUM_SRC];

    assign cand           = cfg__arb__src_enable & ~empty;
    assign arb__sys__busy = (state == XFER) | ~&empty;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [WW-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr, rd_ptr, occ_nxt;
        logic          push, rdy;
        assign push               = src__arb__valid[g] & rdy;
        assign empty[g]           = wr_ptr == rd_ptr;
        assign head[g]            = mem[rd_ptr[AW-1:0]];
        assign occ_nxt            = wr_ptr - rd_ptr + PW'(push) - PW'(pop[g]);
        assign arb__src__ready[g] = rdy;
        // Pointers advance on push/pop; ready is registered from next-cycle occupancy
        always_ff @(posedge clk or posedge reset_poweron) begin
            if (reset_poweron) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                rdy    <= 1'b0;
            end else begin
                wr_ptr <= wr_ptr + PW'(push);
                rd_ptr <= rd_ptr + PW'(pop[g]);
                rdy    <= occ_nxt < PW'(FIFO_DEPTH);
            end
        end
        // Word storage, cntl in the top two bits
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr[AW-1:0]] <= {src__arb__cntl[2*g +: 2], src__arb__data[g*DATA_W +: DATA_W]};
        end
    end

    // Round-robin scan starting just after the last packet owner
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = SRC_ID_W'((int'(rr) + k) % NUM_SRC);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next state, pops and output mux; enable only matters while choosing in IDLE
    always_comb begin
        state_nxt        = state;
        grant_nxt        = grant;
        rr_nxt           = rr;
        pop              = '0;
        drop             = 1'b0;
        arb__dst__valid  = 1'b0;
        arb__dst__cntl   = '0;
        arb__dst__data   = '0;
        arb__dst__src_id = '0;
        if (state == IDLE) begin
            if (found && head[win][DATA_W]) begin
                grant_nxt = win;
                state_nxt = XFER;
            end else if (found) begin
                pop[win] = 1'b1;
                drop     = 1'b1;
            end
        end else begin
            arb__dst__valid                  = !empty[grant];
            {arb__dst__cntl, arb__dst__data} = head[grant];
            arb__dst__src_id                 = grant;
            if (arb__dst__valid && dst__arb__ready) begin
                pop[grant] = 1'b1;
                if (head[grant][DATA_W+1]) begin
                    rr_nxt    = grant;
                    state_nxt = IDLE;
                end
            end
        end
    end

    // State, round-robin pointer, grant and error pulse registers
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state               <= IDLE;
            rr                  <= SRC_ID_W'(NUM_SRC - 1);
            grant               <= '0;
            arb__sys__proto_err <= 1'b0;
        end else begin
            state               <= state_nxt;
            rr                  <= rr_nxt;
            grant               <= grant_nxt;
            arb__sys__proto_err <= drop;
        end
    end
endmodule
